alu_pext: RTL and testbench
===========================

Name: alu_pext

Overview:
- Packed-SIMD (RISC-V P-extension Zpn subset) ALU beside the Ibex integer ALU in the EX stage.
- Performs 8/16-bit lane add/sub, with wrap, halving and saturating variants.
- Also performs 16-bit lane shifts, saturating 32-bit left shift, and two 2-cycle multiply ops.
- Reports lane saturation to the core's OV (vxsat) logic.

Parameters:
- none

Ports:
- clk_i  in  1  clock; all flops rising-edge.
- rst_i  in  1  asynchronous reset, active-high.
- zpn_instr_i  in  1  P-ext instruction valid this cycle.
- zpn_operator_i  in  5  operation select; encoding under Behaviour.
- operand_a_i  in  32  rs1.
- operand_b_i  in  32  rs2.
- operand_rd_i  in  32  rd old value (accumulate source).
- imm_val_i  in  5  immediate shift amount.
- result_o  out  32  result.
- valid_o  out  1  result valid this cycle.
- set_ov_o  out  1  any lane saturated this result.

Behaviour:

Reset:
- FSM to IDLE; partial register (32b) and ov flag cleared.
- Outputs are combinational, so they are 0 whenever zpn_instr_i=0.

zpn_instr_i=0:
- result_o=0, valid_o=0, set_ov_o=0.
- FSM forced to IDLE on the next edge.

Encoding, lane-wise (lane i = bits of each element):
- 0 ADD16: wrap.
- 1 RADD16: signed (a+b)>>1 at 17-bit precision.
- 2 KADD16: signed saturate to [8000,7FFF].
- 3 UKADD16: unsigned saturate to FFFF.
- 4 SUB16: wrap.
- 5 KSUB16: signed saturate.
- 6 ADD8: wrap.
- 7 KADD8: signed saturate to [80,7F].
- 8 SUB8: wrap.
- 9 KSUB8: signed saturate.
- 10 SLL16: amount b[3:0].
- 11 SLLI16: amount imm[3:0].
- 12 KSLL16: amount b[3:0], signed saturate.
- 13 KSLLW: 32-bit a << b[4:0], signed saturate to 7FFFFFFF/80000000.
- 14 KSLLIW: as 13 with imm_val_i.
- 15 SRA16: arithmetic, amount b[3:0].
- 16 KHM16: per lane (a*b)>>15 signed; 8000*8000 -> 7FFF with saturation.
- 17 SMAQA: rd + sum of four signed 8x8 products, 32-bit wrap.
- 18–31: result 0, valid_o=1, set_ov_o=0.

Saturation detection:
- A lane saturates iff its exact result falls outside the lane range.
- For shifts: iff any bit shifted out, or the new sign bit, differs from the original sign.
- set_ov_o = OR over lanes; not sticky (the core accumulates it).

Single-cycle ops (0–15, 18–31):
- valid_o=1 combinationally in the same cycle; FSM stays IDLE.

Multi-cycle ops (16, 17), FSM IDLE/MUL2:
- Cycle 1 (IDLE): compute lane 0 (KHM16), or products of bytes 0–1 plus rd (SMAQA).
- Cycle 1 outputs: valid_o=0, result_o=0, set_ov_o=0.
- At the end of cycle 1: register the partial and the lane-0 ov; go to MUL2.
- Cycle 2 (MUL2): compute the upper lane/bytes and combine with the registered partial.
- Cycle 2 outputs: valid_o=1, set_ov_o = registered ov OR new ov; return to IDLE.
- Operands must be held stable across both cycles; a change of operator in MUL2 is unsupported.
- Latency is exactly 2 cycles; back-to-back multi-cycle ops restart from IDLE.
- Reset asserted mid-operation: FSM to IDLE immediately; valid_o=0.

Optional Feature:
- Macro: PEXT_MULT_EN.
- Defined: ops 16/17 behave as above.
- Undefined: ops 16/17 decode as the 18–31 class (result 0, valid_o=1 in one cycle), and the FSM and partial register are not synthesized.

Test Plan:
- KSLLW a=FF7FFFFF b=00000008 -> result 80000000, set_ov_o=1, valid_o=1 same cycle.
- KADD16 a=7FFF0001 b=00010002 -> 7FFF0003, set_ov_o=1. ADD8 a=FF010203 b=01010101 -> 00020304, set_ov_o=0.
- RADD16 a=7FFF7FFF b=7FFF8000 -> 7FFFFFFF, set_ov_o=0. SRA16 a=8000FFF0 b=4 -> F800FFFF.
- KHM16 a=80000100 b=80000200:
  - Cycle 1: valid_o=0.
  - Cycle 2: result 7FFF0004, set_ov_o=1, valid_o=1.
- SMAQA rd=00000010 a=01020304 b=01010101 -> cycle 2 result 0000001A, set_ov_o=0.
- Reset during KHM16 cycle 1 -> valid_o=0. After reset release, KHM16 again completes in exactly 2 cycles. zpn_instr_i=0 -> all outputs 0.

Source files
------------

// File: rtl/alu_pext.sv
// alu_pext: packed-SIMD (P-ext Zpn subset) ALU; define PEXT_MULT_EN to build the 2-cycle KHM16/SMAQA path
module alu_pext (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        zpn_instr_i,
    input  logic [4:0]  zpn_operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_rd_i,
    input  logic [4:0]  imm_val_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        set_ov_o
);

    function automatic logic [16:0] lane16(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] sh);
        logic [16:0] sum, dif, usum;
        logic [31:0] shl;
        logic        ss, sd, sl;
        sum  = {a[15], a} + {b[15], b};
        dif  = {a[15], a} - {b[15], b};
        usum = {1'b0, a} + {1'b0, b};
        shl  = {{16{a[15]}}, a} << sh;
        ss   = sum[16] ^ sum[15];
        sd   = dif[16] ^ dif[15];
        sl   = shl[31:15] != {17{a[15]}};
        case (op)
            5'd0:         return {1'b0, sum[15:0]};
            5'd1:         return {1'b0, sum[16:1]};
            5'd2:         return {ss, ss ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0]};
            5'd3:         return {usum[16], usum[16] ? 16'hffff : usum[15:0]};
            5'd4:         return {1'b0, dif[15:0]};
            5'd5:         return {sd, sd ? (dif[16] ? 16'h8000 : 16'h7fff) : dif[15:0]};
            5'd10, 5'd11: return {1'b0, shl[15:0]};
            5'd12:        return {sl, sl ? (a[15] ? 16'h8000 : 16'h7fff) : shl[15:0]};
            5'd15:        return {1'b0, 16'($signed(a) >>> sh)};
            default:      return 17'd0;
        endcase
    endfunction

    function automatic logic [8:0] lane8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum, dif;
        logic       ss, sd;
        sum = {a[7], a} + {b[7], b};
        dif = {a[7], a} - {b[7], b};
        ss  = sum[8] ^ sum[7];
        sd  = dif[8] ^ dif[7];
        case (op)
            5'd6:    return {1'b0, sum[7:0]};
            5'd7:    return {ss, ss ? (sum[8] ? 8'h80 : 8'h7f) : sum[7:0]};
            5'd8:    return {1'b0, dif[7:0]};
            5'd9:    return {sd, sd ? (dif[8] ? 8'h80 : 8'h7f) : dif[7:0]};
            default: return 9'd0;
        endcase
    endfunction

    logic [3:0]  sh16;
    logic [4:0]  sh32;
    logic [31:0] res_s;
    logic        ov_s;
    logic        is_mul;
    logic        act;
    logic [31:0] mul_r;
    logic        mul_v;
    logic        mul_o;

    assign sh16   = (zpn_operator_i == 5'd11) ? imm_val_i[3:0] : operand_b_i[3:0];
    assign sh32   = (zpn_operator_i == 5'd14) ? imm_val_i : operand_b_i[4:0];
    assign is_mul = (zpn_operator_i == 5'd16) || (zpn_operator_i == 5'd17);

    // Single-cycle ops: compute every lane and OR the per-lane saturation flags
    always_comb begin
        logic [16:0] r16;
        logic [8:0]  r8;
        logic [63:0] w;
        logic        ws;
        r16   = '0;
        r8    = '0;
        res_s = '0;
        ov_s  = 1'b0;
        w     = {{32{operand_a_i[31]}}, operand_a_i} << sh32;
        ws    = w[63:31] != {33{operand_a_i[31]}};
        if (zpn_operator_i == 5'd13 || zpn_operator_i == 5'd14) begin
            res_s = ws ? (operand_a_i[31] ? 32'h80000000 : 32'h7fffffff) : w[31:0];
            ov_s  = ws;
        end else if (zpn_operator_i >= 5'd6 && zpn_operator_i <= 5'd9) begin
            for (int i = 0; i < 4; i++) begin
                r8             = lane8(zpn_operator_i, operand_a_i[8*i+:8], operand_b_i[8*i+:8]);
                res_s[8*i+:8]  = r8[7:0];
                ov_s           = ov_s | r8[8];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r16             = lane16(zpn_operator_i, operand_a_i[16*i+:16], operand_b_i[16*i+:16], sh16);
                res_s[16*i+:16] = r16[15:0];
                ov_s            = ov_s | r16[16];
            end
        end
    end

`ifdef PEXT_MULT_EN
    typedef enum logic {IDLE, MUL2} state_e;

    state_e             state_q, state_d;
    logic [31:0]        part_q, part_d;
    logic               ov_q, ov_d;
    logic               hi;
    logic               is_khm;
    logic [15:0]        ka, kb, kr;
    logic signed [31:0] kp;
    logic               ks;
    logic [7:0]         xa0, xa1, xb0, xb1;
    logic signed [15:0] p0, p1;
    logic [31:0]        acc;

    assign hi     = state_q == MUL2;
    assign is_khm = zpn_operator_i == 5'd16;

    // Multiply datapath: lower half in IDLE, upper half in MUL2 combined with the stored partial
    always_comb begin
        ka      = hi ? operand_a_i[31:16] : operand_a_i[15:0];
        kb      = hi ? operand_b_i[31:16] : operand_b_i[15:0];
        kp      = $signed(ka) * $signed(kb);
        ks      = (ka == 16'h8000) && (kb == 16'h8000);
        kr      = ks ? 16'h7fff : 16'(kp >>> 15);
        xa0     = hi ? operand_a_i[23:16] : operand_a_i[7:0];
        xa1     = hi ? operand_a_i[31:24] : operand_a_i[15:8];
        xb0     = hi ? operand_b_i[23:16] : operand_b_i[7:0];
        xb1     = hi ? operand_b_i[31:24] : operand_b_i[15:8];
        p0      = $signed(xa0) * $signed(xb0);
        p1      = $signed(xa1) * $signed(xb1);
        acc     = (hi ? part_q : operand_rd_i) + {{16{p0[15]}}, p0} + {{16{p1[15]}}, p1};
        mul_v   = hi;
        mul_r   = hi ? (is_khm ? {kr, part_q[15:0]} : acc) : 32'd0;
        mul_o   = hi & (ov_q | (is_khm & ks));
        state_d = (zpn_instr_i && is_mul && !hi) ? MUL2 : IDLE;
        part_d  = hi ? part_q : (is_khm ? {16'd0, kr} : acc);
        ov_d    = hi ? ov_q : (is_khm & ks);
    end

    // FSM state, partial result and lane-0 overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            part_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            ov_q    <= ov_d;
        end
    end
`else
    logic unused_mul;

    assign mul_v      = 1'b1;
    assign mul_r      = 32'd0;
    assign mul_o      = 1'b0;
    assign unused_mul = ^{clk_i, operand_rd_i};
`endif

    assign act      = zpn_instr_i & ~rst_i;
    assign valid_o  = act & (is_mul ? mul_v : 1'b1);
    assign result_o = act ? (is_mul ? mul_r : res_s) : 32'd0;
    assign set_ov_o = act & (is_mul ? mul_o : ov_s);

endmodule

// File: tb/tb_alu_pext.sv
// tb_alu_pext: vector table plus multi-cycle sequences, checked through an expected-result queue
module tb_alu_pext;

    logic        clk = 1'b0;
    logic        rst, zpn, valid, ov;
    logic [4:0]  op, imm;
    logic [31:0] a, b, rd, res;

    always #5 clk = ~clk;

    alu_pext dut (
        .clk_i(clk), .rst_i(rst), .zpn_instr_i(zpn), .zpn_operator_i(op),
        .operand_a_i(a), .operand_b_i(b), .operand_rd_i(rd), .imm_val_i(imm),
        .result_o(res), .valid_o(valid), .set_ov_o(ov)
    );

    typedef struct packed { logic [31:0] res; logic ov; } exp_t;
    typedef struct { logic [4:0] op; logic [31:0] a, b; logic [4:0] imm; logic [31:0] res; logic ov; } vec_t;

    exp_t sb[$];
    vec_t tv[20];
    int   tests = 0;
    int   fails = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act_v, exp_v);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xrd, input logic [4:0] xi);
        @(posedge clk);
        #1;
        zpn = 1'b1; op = o; a = xa; b = xb; rd = xrd; imm = xi;
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        @(negedge clk);
        if (valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s valid: got %b want 1", nm, valid);
        end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: output with no expected entry, got %h", nm, res);
        end else begin
            e = sb.pop_front();
            chk({nm, " result"}, res, e.res);
            chk({nm, " ov"}, 32'(ov), 32'(e.ov));
        end
    endtask

    task automatic mul_seq(input string nm, input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                           input logic [31:0] xrd, input logic [31:0] eres, input logic eov);
        drive(o, xa, xb, xrd, 5'd0);
`ifdef PEXT_MULT_EN
        sb.push_back('{eres, eov});
        @(negedge clk);
        chk({nm, " c1 valid"}, 32'(valid), 32'd0);
        chk({nm, " c1 result"}, res, 32'd0);
`else
        sb.push_back('{32'd0, 1'b0});
`endif
        pop_chk(nm);
    endtask

    task automatic idle_chk(input string nm);
        @(posedge clk);
        #1;
        zpn = 1'b0; op = 5'd0; a = 32'hffffffff; b = 32'hffffffff;
        @(negedge clk);
        chk({nm, " result"}, res, 32'd0);
        chk({nm, " valid"}, 32'(valid), 32'd0);
        chk({nm, " ov"}, 32'(ov), 32'd0);
    endtask

    initial begin
        rst = 1'b1; zpn = 1'b0; op = '0; a = '0; b = '0; rd = '0; imm = '0;
        tv[0]  = '{5'd13, 32'hFF7FFFFF, 32'h00000008, 5'd0,  32'h80000000, 1'b1};
        tv[1]  = '{5'd2,  32'h7FFF0001, 32'h00010002, 5'd0,  32'h7FFF0003, 1'b1};
        tv[2]  = '{5'd6,  32'hFF010203, 32'h01010101, 5'd0,  32'h00020304, 1'b0};
        tv[3]  = '{5'd1,  32'h7FFF7FFF, 32'h7FFF8000, 5'd0,  32'h7FFFFFFF, 1'b0};
        tv[4]  = '{5'd15, 32'h8000FFF0, 32'h00000004, 5'd0,  32'hF800FFFF, 1'b0};
        tv[5]  = '{5'd0,  32'hFFFF1234, 32'h00011111, 5'd0,  32'h00002345, 1'b0};
        tv[6]  = '{5'd3,  32'hFFFF1000, 32'h00010001, 5'd0,  32'hFFFF1001, 1'b1};
        tv[7]  = '{5'd4,  32'h00000005, 32'h00010007, 5'd0,  32'hFFFFFFFE, 1'b0};
        tv[8]  = '{5'd5,  32'h80000005, 32'h00010007, 5'd0,  32'h8000FFFE, 1'b1};
        tv[9]  = '{5'd7,  32'h7F800102, 32'h01FF0304, 5'd0,  32'h7F800406, 1'b1};
        tv[10] = '{5'd8,  32'h00010203, 32'h01010101, 5'd0,  32'hFF000102, 1'b0};
        tv[11] = '{5'd9,  32'h807F1000, 32'h01FF2000, 5'd0,  32'h807FF000, 1'b1};
        tv[12] = '{5'd10, 32'h80011234, 32'h00000004, 5'd0,  32'h00102340, 1'b0};
        tv[13] = '{5'd11, 32'h00010003, 32'hFFFFFFFF, 5'd3,  32'h00080018, 1'b0};
        tv[14] = '{5'd12, 32'h40000001, 32'h00000001, 5'd0,  32'h7FFF0002, 1'b1};
        tv[15] = '{5'd12, 32'hFFFFC000, 32'h00000001, 5'd0,  32'hFFFE8000, 1'b0};
        tv[16] = '{5'd14, 32'h00000001, 32'h00000000, 5'd30, 32'h40000000, 1'b0};
        tv[17] = '{5'd13, 32'h00000001, 32'h0000001F, 5'd0,  32'h7FFFFFFF, 1'b1};
        tv[18] = '{5'd20, 32'h7FFF0001, 32'h00010002, 5'd0,  32'h00000000, 1'b0};
        tv[19] = '{5'd2,  32'h7FFE0000, 32'h00010000, 5'd0,  32'h7FFF0000, 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset result", res, 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset ov", 32'(ov), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(tv[i].op, tv[i].a, tv[i].b, 32'd0, tv[i].imm);
            sb.push_back('{tv[i].res, tv[i].ov});
            pop_chk($sformatf("vec%0d op%0d", i, tv[i].op));
        end
        idle_chk("idle");
        mul_seq("khm16", 5'd16, 32'h80000100, 32'h80000200, 32'd0, 32'h7FFF0004, 1'b1);
        mul_seq("smaqa", 5'd17, 32'h01020304, 32'h01010101, 32'h00000010, 32'h0000001A, 1'b0);
        mul_seq("khm16 b2b", 5'd16, 32'h40000100, 32'h40000200, 32'd0, 32'h20000004, 1'b0);
        mul_seq("khm16 neg", 5'd16, 32'hFFFF0100, 32'h00020200, 32'd0, 32'hFFFF0004, 1'b0);
        mul_seq("smaqa neg", 5'd17, 32'hFFFF8080, 32'h0102807F, 32'd0, 32'h0000007D, 1'b0);
        drive(5'd16, 32'h80000100, 32'h80000200, 32'd0, 5'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef PEXT_MULT_EN
        sb.push_back('{32'h7FFF0004, 1'b1});
        @(negedge clk);
        chk("post rst c1 valid", 32'(valid), 32'd0);
`else
        sb.push_back('{32'd0, 1'b0});
`endif
        pop_chk("post rst khm16");
        drive(5'd16, 32'h80000100, 32'h80000200, 32'd0, 5'd0);
        idle_chk("abort idle");
        mul_seq("after abort", 5'd16, 32'h40000100, 32'h40000200, 32'd0, 32'h20000004, 1'b0);
        idle_chk("final idle");
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
